// File: rtl/regfile_pkg.sv
// Register bank shared definitions.
// Used by the bank, decode and the writeback controller.
package regfile_pkg;

  localparam int DEFAULT_REGISTER_SIZE = 32;
  localparam int DEFAULT_ADDRESS_SIZE  = 5;
  localparam int ZERO_REG              = 0;

  typedef struct packed {
    logic                             valid;
    logic [DEFAULT_ADDRESS_SIZE-1:0]  addr;
    logic [DEFAULT_REGISTER_SIZE-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest request at or after ptr wins.
// One-hot grant; no grant when no request.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Try requests at/above ptr first, else wrap.
  always_comb begin
    mask  = ~((N'(1) << ptr) - N'(1));
    hi    = req & mask;
    pick  = (|hi) ? hi : req;
    grant = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback controller: per-source slots, RR onto one write port.
// Optional bypass lookup enabled by defining WB_BYPASS_EN.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE,
  parameter int ADDRESS_SIZE  = DEFAULT_ADDRESS_SIZE,
  parameter int NUM_SRC       = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*ADDRESS_SIZE-1:0]  src_addr,
  input  logic [NUM_SRC*REGISTER_SIZE-1:0] src_data,
  output logic                             rf_write,
  output logic [ADDRESS_SIZE-1:0]          rf_addr,
  output logic [REGISTER_SIZE-1:0]         rf_data,
  output logic                             busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDRESS_SIZE-1:0]          byp_addr1,
  input  logic [ADDRESS_SIZE-1:0]          byp_addr2,
  output logic                             byp_hit1,
  output logic                             byp_hit2,
  output logic [REGISTER_SIZE-1:0]         byp_data1,
  output logic [REGISTER_SIZE-1:0]         byp_data2
`endif
);

  localparam int AS = ADDRESS_SIZE;
  localparam int RS = REGISTER_SIZE;
  localparam int PW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] slot_valid;
  logic [NUM_SRC-1:0] grant;
  logic [AS-1:0]      slot_addr [NUM_SRC];
  logic [RS-1:0]      slot_data [NUM_SRC];
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_nxt;
  logic [AS-1:0]      sel_addr;
  logic [RS-1:0]      sel_data;

  rr_arbiter #(
    .N  (NUM_SRC),
    .PW (PW)
  ) u_arb (
    .req   (slot_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign src_ready = ~slot_valid | grant;
  assign busy      = (|slot_valid) | rf_write;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    ptr_nxt  = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_addr = slot_addr[i];
        sel_data = slot_data[i];
        ptr_nxt  = (i == NUM_SRC-1) ? '0 : PW'(i+1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
      ptr      <= '0;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else begin
      // Writes to r0 complete the handshake but never occupy a slot.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i] &&
            src_addr[i*AS +: AS] != AS'(ZERO_REG)) begin
          slot_valid[i] <= 1'b1;
          slot_addr[i]  <= src_addr[i*AS +: AS];
          slot_data[i]  <= src_data[i*RS +: RS];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      ptr      <= ptr_nxt;
      rf_write <= |grant;
      if (|grant) begin
        rf_addr <= sel_addr;
        rf_data <= sel_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  function automatic logic [RS:0] lookup(input logic [AS-1:0] a);
    logic [RS:0] r;
    r = '0;
    if (rf_write && rf_addr == a)
      r = {1'b1, rf_data};
    // Descending scan so the lowest matching slot wins.
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (slot_valid[i] && slot_addr[i] == a)
        r = {1'b1, slot_data[i]};
    end
    if (a == AS'(ZERO_REG))
      r = '0;
    return r;
  endfunction

  always_comb {byp_hit1, byp_data1} = lookup(byp_addr1);
  always_comb {byp_hit2, byp_data2} = lookup(byp_addr2);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback.
// Bypass scenario runs only when WB_BYPASS_EN is defined.
module tb_regfile_writeback;

  localparam int NS = 3;
  localparam int AS = 5;
  localparam int RS = 32;

  logic             clk;
  logic             reset;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*AS-1:0] src_addr;
  logic [NS*RS-1:0] src_data;
  logic             rf_write;
  logic [AS-1:0]    rf_addr;
  logic [RS-1:0]    rf_data;
  logic             busy;
`ifdef WB_BYPASS_EN
  logic [AS-1:0]    byp_addr1;
  logic [AS-1:0]    byp_addr2;
  logic             byp_hit1;
  logic             byp_hit2;
  logic [RS-1:0]    byp_data1;
  logic [RS-1:0]    byp_data2;
`endif

  regfile_writeback #(
    .REGISTER_SIZE (RS),
    .ADDRESS_SIZE  (AS),
    .NUM_SRC       (NS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .rf_write  (rf_write),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .busy      (busy)
`ifdef WB_BYPASS_EN
    ,
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  typedef struct {
    int          src;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          log_q[$];
  int          vectors;
  int          miscompares;
  bit          mon_en;
  logic [31:0] bank [32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (rf_write) bank[rf_addr] <= rf_data;

  always @(negedge clk) begin
    int idx;
    if (reset && mon_en && rf_write) begin
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].addr == rf_addr) idx = i;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, want no write",
                 rf_addr, rf_data);
      end else begin
        if (rf_data !== exp_q[idx].data) begin
          miscompares++;
          $display("FAIL wb_data r%0d: got %h want %h",
                   rf_addr, rf_data, exp_q[idx].data);
        end
        log_q.push_back(exp_q[idx].src);
        exp_q.delete(idx);
      end
    end
  end

  task automatic offer(input int s, input logic [4:0] a,
                       input logic [31:0] d, output int waited);
    src_valid[s]        = 1'b1;
    src_addr[s*AS +: AS] = a;
    src_data[s*RS +: RS] = d;
    waited = 0;
    #1;
    while (!src_ready[s] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (!src_ready[s]) begin
      miscompares++;
      $display("FAIL offer_timeout src%0d: ready=0 after %0d cycles, want 1",
               s, waited);
    end else begin
      @(posedge clk);
      if (a != 5'd0) exp_q.push_back('{s, a, d});
    end
    @(negedge clk);
    src_valid[s] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: busy=%b pending=%0d, want busy=0 pending=0",
               name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    src_valid = '0;
    repeat (2) @(negedge clk);
    vectors += 5;
    if (rf_write !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rf_write: got %b want 0", rf_write);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    if (rf_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_rf_addr: got %0d want 0", rf_addr);
    end
    if (rf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_rf_data: got %h want 0", rf_data);
    end
    if (src_ready !== 3'b111) begin
      miscompares++;
      $display("FAIL rst_ready: got %b want 111", src_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int          cnt [NS];
    logic [2:0]  rdy;
    logic [2:0]  want;
    logic [31:0] d;
    log_q.delete();
    for (int s = 0; s < NS; s++) cnt[s] = 0;
    for (int c = 0; c < 9; c++) begin
      for (int s = 0; s < NS; s++) begin
        src_valid[s]         = 1'b1;
        src_addr[s*AS +: AS] = 5'(s + 1);
        src_data[s*RS +: RS] = {8'(s), 24'(cnt[s])};
      end
      #1;
      rdy  = src_ready;
      want = (c == 0) ? 3'b111 : 3'(1 << ((c - 1) % 3));
      vectors++;
      if (rdy !== want) begin
        miscompares++;
        $display("FAIL rr_ready cyc%0d: got %b want %b", c, rdy, want);
      end
      @(posedge clk);
      for (int s = 0; s < NS; s++) begin
        if (rdy[s]) begin
          d = {8'(s), 24'(cnt[s])};
          exp_q.push_back('{s, 5'(s + 1), d});
          cnt[s]++;
        end
      end
      @(negedge clk);
    end
    src_valid = '0;
    drain("rr");
    vectors++;
    if (log_q.size() != 11) begin
      miscompares++;
      $display("FAIL rr_count: got %0d writes want 11", log_q.size());
    end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] != i % 3) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got src%0d want src%0d",
                 i, log_q[i], i % 3);
      end
    end
  endtask

  task automatic test_single;
    int w;
    offer(0, 5'd5, 32'hDEADBEEF, w);
    vectors += 5;
    if (w != 0) begin
      miscompares++;
      $display("FAIL single_ready: waited %0d want 0", w);
    end
    if (rf_write !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: rf_write=%b want 0", rf_write);
    end
    @(negedge clk);
    if (rf_write !== 1'b1) begin
      miscompares++;
      $display("FAIL single_write: rf_write=%b want 1", rf_write);
    end
    if (rf_addr !== 5'd5) begin
      miscompares++;
      $display("FAIL single_addr: got %0d want 5", rf_addr);
    end
    @(negedge clk);
    if (bank[5] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_bank: got %h want deadbeef", bank[5]);
    end
    drain("single");
  endtask

  task automatic test_r0_drop;
    int w;
    offer(1, 5'd0, 32'h1234, w);
    vectors += 3;
    if (w != 0) begin
      miscompares++;
      $display("FAIL r0_ready: waited %0d want 0", w);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_busy: got %b want 0", busy);
    end
    if (src_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_slot: ready=%b want 1", src_ready[1]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (rf_write !== 1'b0) begin
        miscompares++;
        $display("FAIL r0_write cyc%0d: got %b want 0", c, rf_write);
      end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass;
    int w;
    offer(0, 5'd7, 32'hB, w);
    offer(0, 5'd7, 32'hA, w);
    byp_addr1 = 5'd7;
    byp_addr2 = 5'd0;
    #1;
    vectors += 5;
    if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hA) begin
      miscompares++;
      $display("FAIL byp_slot: hit=%b data=%h want 1/a", byp_hit1, byp_data1);
    end
    if (byp_hit2 !== 1'b0 || byp_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL byp_r0: hit=%b data=%h want 0/0", byp_hit2, byp_data2);
    end
    byp_addr2 = 5'd8;
    #1;
    if (byp_hit2 !== 1'b0 || byp_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL byp_miss: hit=%b data=%h want 0/0", byp_hit2, byp_data2);
    end
    @(negedge clk);
    if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hA) begin
      miscompares++;
      $display("FAIL byp_outreg: hit=%b data=%h want 1/a", byp_hit1, byp_data1);
    end
    if (w != 0) begin
      miscompares++;
      $display("FAIL byp_reload: waited %0d want 0", w);
    end
    drain("byp");
    byp_addr1 = 5'd0;
    byp_addr2 = 5'd0;
  endtask
`endif

  task automatic test_back_to_back;
    int w1;
    int w2;
    offer(2, 5'd9, 32'd1, w1);
    offer(2, 5'd9, 32'd2, w2);
    vectors++;
    if (w1 != 0 || w2 != 0) begin
      miscompares++;
      $display("FAIL b2b_ready: waited %0d/%0d want 0/0", w1, w2);
    end
    drain("b2b");
    vectors++;
    if (bank[9] !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_bank: got %h want 2", bank[9]);
    end
  endtask

  task automatic test_reset_mid;
    mon_en = 1'b0;
    for (int s = 0; s < NS; s++) begin
      src_valid[s]         = 1'b1;
      src_addr[s*AS +: AS] = 5'(s + 10);
      src_data[s*RS +: RS] = 32'(s + 100);
    end
    repeat (2) @(negedge clk);
    vectors += 3;
    if (busy !== 1'b1 || rf_write !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: busy=%b rf_write=%b want 1/1", busy, rf_write);
    end
    reset = 1'b0;
    #1;
    if (rf_write !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst: rf_write=%b busy=%b want 0/0", rf_write, busy);
    end
    if (rf_addr !== 5'd0 || rf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_rst_out: addr=%0d data=%h want 0/0", rf_addr, rf_data);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_hold: busy=%b want 0", busy);
    end
    src_valid = '0;
    reset     = 1'b1;
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_release: busy=%b want 0", busy);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b1;
    reset       = 1'b0;
    src_valid   = '0;
    src_addr    = '0;
    src_data    = '0;
`ifdef WB_BYPASS_EN
    byp_addr1   = '0;
    byp_addr2   = '0;
`endif
    test_reset();
    test_round_robin();
    test_single();
    test_r0_drop();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
